voice_allocator: RTL and testbench
==================================

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 88: width of key bitmap.
REQ-002 SHALL have parameter NUM_VOICES, default 4: number of synthesis voices, range 1..16.
REQ-003 SHALL have parameter KEY_W, default 7: key index width, with 2^KEY_W >= NUM_KEYS.
REQ-004 SHALL have parameter AGE_W, default 8: per-voice age counter width.
REQ-005 SHALL have parameter STEAL, default 1: 1 = steal the oldest voice when all are busy; 0 = drop the new note.
REQ-006 SHALL have port iCLK, input, 1: single clock; all logic is on the rising edge.
REQ-007 SHALL have port iRST, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have port iKEYS, input, NUM_KEYS: pressed-key bitmap, bit k = key k held; asynchronous to the scan.
REQ-009 SHALL have port oVOICE_ACTIVE, output, NUM_VOICES: bit v = voice v is sounding.
REQ-010 SHALL have port oVOICE_KEY, output, NUM_VOICES*KEY_W: key index of voice v at bits [v*KEY_W +: KEY_W].
REQ-011 SHALL have port oNOTE_ON, output, 1: one-cycle pulse, a voice was (re)assigned.
REQ-012 SHALL have port oNOTE_OFF, output, 1: one-cycle pulse, a voice was released.
REQ-013 SHALL have port oSTOLEN, output, 1: qualifies oNOTE_ON, meaning the assigned voice was taken from an active note.
REQ-014 SHALL have port oEVT_VOICE, output, 4: voice index for the current oNOTE_ON or oNOTE_OFF.
REQ-015 SHALL have port oSCAN_DONE, output, 1: one-cycle pulse at the end of each scan.

Function
REQ-016 SHALL run FSM states SNAP -> SCAN -> COMMIT -> SNAP continuously; the scan period is NUM_KEYS+2 cycles.
REQ-017 In SNAP, SHALL register iKEYS into cur and clear the scan index to 0.
REQ-018 In SCAN, SHALL evaluate one key per cycle at index k = 0..NUM_KEYS-1, then go to COMMIT after k = NUM_KEYS-1.
REQ-019 SHALL define rise = cur[k] & ~prev[k] and fall = ~cur[k] & prev[k]; iKEYS changes during a scan SHALL NOT affect that scan.
REQ-020 On rise with any inactive voice, SHALL assign the lowest-index inactive voice: active=1, key=k, age=0.
REQ-021 On the same rise, SHALL also increment the age of every other active voice, saturating at 2^AGE_W-1.
REQ-022 On rise with all voices active and STEAL=1, SHALL reassign the voice with the largest age (ties go to the lowest index): key=k, age=0, others aged, oSTOLEN=1.
REQ-023 On rise with all voices active and STEAL=0, SHALL leave the voice state unchanged and emit no event; that key's later fall SHALL produce no event.
REQ-024 On fall, SHALL clear active on the voice whose active key equals k and pulse oNOTE_OFF; if there is no match, it SHALL do nothing.
REQ-025 At most one voice SHALL hold a given key at any time.
REQ-026 Events SHALL be registered: oNOTE_ON/oNOTE_OFF/oSTOLEN/oEVT_VOICE SHALL be valid the cycle after key k is evaluated, with oVOICE_ACTIVE/oVOICE_KEY already updated in that same cycle.
REQ-027 There SHALL be at most one event per cycle; outside events oEVT_VOICE SHALL hold its last value and all pulses SHALL be 0.
REQ-028 In COMMIT, SHALL set prev <= cur and pulse oSCAN_DONE the following cycle.
REQ-029 Inactive voices SHALL retain their last key value; ages of inactive voices SHALL NOT be incremented.

Reset
REQ-030 While iRST=1 at a clock edge, SHALL set state=SNAP, index=0, prev=0, cur=0, all voices inactive, keys=0, ages=0, and all outputs=0.
REQ-031 Reset asserted mid-scan SHALL abandon the scan with no further events; keys held through reset SHALL produce note-ons in the first scan after reset.
REQ-032 The first SNAP SHALL occur in the first cycle after iRST deasserts.

Verification
REQ-033 Test 1: reset, then iKEYS bit 40 set -> one oNOTE_ON with oEVT_VOICE=0, oVOICE_KEY[6:0]=40, oVOICE_ACTIVE=0001, and oSCAN_DONE every 90 cycles.
REQ-034 Test 2: keys 10,20,30,40 pressed together -> four oNOTE_ON events on voices 0..3 in ascending key order; release key 20 -> oNOTE_OFF with oEVT_VOICE=1 and oVOICE_ACTIVE=1101.
REQ-035 Test 3 (STEAL=1): voices hold 10,20,30,40, then key 50 pressed -> oNOTE_ON with oSTOLEN=1 and oEVT_VOICE=0 (oldest), and voice 0 key=50; release key 10 -> no event.
REQ-036 Test 4 (STEAL=0): same as Test 3 -> no event for key 50 and voice state unchanged; release key 50 -> no event.
REQ-037 Test 5: toggle iKEYS bit 5 mid-scan after index 5 has passed -> no event until the next scan.
REQ-038 Test 6: assert iRST during a scan with keys held -> all outputs 0; after deassert, note-ons are re-emitted.
REQ-039 Test 7: rerun Tests 1-3 with NUM_KEYS=12, NUM_VOICES=2, KEY_W=4 -> same behaviour, with a scan period of 14 cycles.

Source files
------------

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - key-bitmap scanner assigning held keys to a fixed pool of synth voices
module voice_allocator #(
  parameter int NUM_KEYS   = 88,
  parameter int NUM_VOICES = 4,
  parameter int KEY_W      = 7,
  parameter int AGE_W      = 8,
  parameter int STEAL      = 1
) (
  input  logic                        iCLK,
  input  logic                        iRST,
  input  logic [NUM_KEYS-1:0]         iKEYS,
  output logic [NUM_VOICES-1:0]       oVOICE_ACTIVE,
  output logic [NUM_VOICES*KEY_W-1:0] oVOICE_KEY,
  output logic                        oNOTE_ON,
  output logic                        oNOTE_OFF,
  output logic                        oSTOLEN,
  output logic [3:0]                  oEVT_VOICE,
  output logic                        oSCAN_DONE
);

  typedef enum logic [1:0] {
    SNAP   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [KEY_W-1:0] LAST_IDX = KEY_W'(NUM_KEYS - 1);
  localparam logic [AGE_W-1:0] AGE_MAX  = {AGE_W{1'b1}};

  state_t              state_q;
  logic [KEY_W-1:0]    idx_q;
  logic [NUM_KEYS-1:0] cur_q;
  logic [NUM_KEYS-1:0] prev_q;

  logic [NUM_VOICES-1:0] active_q;
  logic [KEY_W-1:0]      key_q [NUM_VOICES];
  logic [AGE_W-1:0]      age_q [NUM_VOICES];

  logic       note_on_q;
  logic       note_off_q;
  logic       stolen_q;
  logic       scan_done_q;
  logic [3:0] evt_voice_q;

  // Per-key decision signals for the key currently under the scan index
  logic             rise;
  logic             fall;
  logic             free_found;
  logic [3:0]       free_idx;
  logic             match_found;
  logic [3:0]       match_idx;
  logic [3:0]       old_idx;
  logic [AGE_W-1:0] old_age;
  logic [3:0]       tgt_idx;
  logic             do_on;
  logic             do_off;

  // Edge detection on the snapshot, plus free/matching/oldest voice search
  always_comb begin
    rise        = cur_q[idx_q] & ~prev_q[idx_q];
    fall        = ~cur_q[idx_q] & prev_q[idx_q];
    free_found  = 1'b0;
    free_idx    = 4'd0;
    match_found = 1'b0;
    match_idx   = 4'd0;
    old_idx     = 4'd0;
    old_age     = age_q[0];
    // Descending walk so the lowest inactive voice wins
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!active_q[v]) begin
        free_found = 1'b1;
        free_idx   = 4'(v);
      end
    end
    // Only one active voice can ever hold a given key
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (active_q[v] && (key_q[v] == idx_q)) begin
        match_found = 1'b1;
        match_idx   = 4'(v);
      end
    end
    // Strict greater-than keeps ties on the lowest index
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (age_q[v] > old_age) begin
        old_age = age_q[v];
        old_idx = 4'(v);
      end
    end
    tgt_idx = free_found ? free_idx : old_idx;
    do_on   = (state_q == SCAN) && rise && (free_found || (STEAL != 0));
    do_off  = (state_q == SCAN) && fall && match_found;
  end

  // Scan FSM with voice table updates and registered event outputs
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q     <= SNAP;
      idx_q       <= '0;
      cur_q       <= '0;
      prev_q      <= '0;
      active_q    <= '0;
      note_on_q   <= 1'b0;
      note_off_q  <= 1'b0;
      stolen_q    <= 1'b0;
      scan_done_q <= 1'b0;
      evt_voice_q <= 4'd0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        key_q[v] <= '0;
        age_q[v] <= '0;
      end
    end else begin
      note_on_q   <= 1'b0;
      note_off_q  <= 1'b0;
      stolen_q    <= 1'b0;
      scan_done_q <= 1'b0;
      case (state_q)
        SNAP: begin
          // The key bitmap is only ever sampled here, so mid-scan changes wait a scan
          cur_q   <= iKEYS;
          idx_q   <= '0;
          state_q <= SCAN;
        end
        SCAN: begin
          if (do_on) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
              if (4'(v) == tgt_idx) begin
                active_q[v] <= 1'b1;
                key_q[v]    <= idx_q;
                age_q[v]    <= '0;
              end else if (active_q[v] && (age_q[v] != AGE_MAX)) begin
                age_q[v] <= age_q[v] + 1'b1;
              end
            end
            note_on_q   <= 1'b1;
            stolen_q    <= ~free_found;
            evt_voice_q <= tgt_idx;
          end else if (do_off) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
              if (4'(v) == match_idx) begin
                active_q[v] <= 1'b0;
              end
            end
            note_off_q  <= 1'b1;
            evt_voice_q <= match_idx;
          end
          if (idx_q == LAST_IDX) begin
            state_q <= COMMIT;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        COMMIT: begin
          prev_q      <= cur_q;
          scan_done_q <= 1'b1;
          state_q     <= SNAP;
        end
        default: begin
          state_q <= SNAP;
        end
      endcase
    end
  end

  // Flatten the voice key table onto the output bus
  always_comb begin
    oVOICE_KEY = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      oVOICE_KEY[v*KEY_W +: KEY_W] = key_q[v];
    end
  end

  assign oVOICE_ACTIVE = active_q;
  assign oNOTE_ON      = note_on_q;
  assign oNOTE_OFF     = note_off_q;
  assign oSTOLEN       = stolen_q;
  assign oEVT_VOICE    = evt_voice_q;
  assign oSCAN_DONE    = scan_done_q;

endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - directed vector bench for voice_allocator
module tb_voice_allocator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [87:0] keys_a, keys_n;
  logic [11:0] keys_s;

  logic [3:0]  act_a, act_n;
  logic [1:0]  act_s;
  logic [27:0] vk_a, vk_n;
  logic [7:0]  vk_s;
  logic        on_a, off_a, st_a, done_a;
  logic        on_n, off_n, st_n, done_n;
  logic        on_s, off_s, st_s, done_s;
  logic [3:0]  evt_a, evt_n, evt_s;

  voice_allocator u_dut_a (
    .iCLK(clk), .iRST(rst), .iKEYS(keys_a),
    .oVOICE_ACTIVE(act_a), .oVOICE_KEY(vk_a),
    .oNOTE_ON(on_a), .oNOTE_OFF(off_a), .oSTOLEN(st_a),
    .oEVT_VOICE(evt_a), .oSCAN_DONE(done_a)
  );

  voice_allocator #(.STEAL(0)) u_dut_n (
    .iCLK(clk), .iRST(rst), .iKEYS(keys_n),
    .oVOICE_ACTIVE(act_n), .oVOICE_KEY(vk_n),
    .oNOTE_ON(on_n), .oNOTE_OFF(off_n), .oSTOLEN(st_n),
    .oEVT_VOICE(evt_n), .oSCAN_DONE(done_n)
  );

  voice_allocator #(.NUM_KEYS(12), .NUM_VOICES(2), .KEY_W(4)) u_dut_s (
    .iCLK(clk), .iRST(rst), .iKEYS(keys_s),
    .oVOICE_ACTIVE(act_s), .oVOICE_KEY(vk_s),
    .oNOTE_ON(on_s), .oNOTE_OFF(off_s), .oSTOLEN(st_s),
    .oEVT_VOICE(evt_s), .oSCAN_DONE(done_s)
  );

  int          sel;
  logic [3:0]  mon_act;
  logic [27:0] mon_vk;
  logic        mon_on, mon_off, mon_st, mon_done;
  logic [3:0]  mon_evt;

  always_comb begin
    mon_act = act_a; mon_vk = vk_a; mon_on = on_a; mon_off = off_a;
    mon_st = st_a; mon_evt = evt_a; mon_done = done_a;
    if (sel == 1) begin
      mon_act = act_n; mon_vk = vk_n; mon_on = on_n; mon_off = off_n;
      mon_st = st_n; mon_evt = evt_n; mon_done = done_n;
    end else if (sel == 2) begin
      mon_act = {2'b00, act_s}; mon_vk = {20'd0, vk_s}; mon_on = on_s; mon_off = off_s;
      mon_st = st_s; mon_evt = evt_s; mon_done = done_s;
    end
  end

  typedef struct {
    int          dut;
    logic [87:0] keys;
    bit          mid_en;
    logic [87:0] mid;
    int          n_ev;
    logic [31:0] ev;
    logic [3:0]  act;
    logic [27:0] vk;
    int          period;
  } vec_t;

  vec_t vt[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [87:0] kb(int a = -1, int b = -1, int c = -1, int d = -1, int e = -1);
    logic [87:0] r = '0;
    if (a >= 0) r[a] = 1'b1;
    if (b >= 0) r[b] = 1'b1;
    if (c >= 0) r[c] = 1'b1;
    if (d >= 0) r[d] = 1'b1;
    if (e >= 0) r[e] = 1'b1;
    return r;
  endfunction

  function automatic logic [27:0] pk4(int a, int b, int c, int d);
    return 28'(a) | (28'(b) << 7) | (28'(c) << 14) | (28'(d) << 21);
  endfunction

  function automatic vec_t mkv(int d, logic [87:0] k, bit me, logic [87:0] mk, int n,
                               logic [31:0] ev, logic [3:0] act, logic [27:0] vk);
    vec_t v;
    v.dut = d; v.keys = k; v.mid_en = me; v.mid = mk; v.n_ev = n;
    v.ev = ev; v.act = act; v.vk = vk; v.period = (d == 2) ? 14 : 90;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic set_keys(input int d, input logic [87:0] k);
    if (d == 0) keys_a = k;
    else if (d == 1) keys_n = k;
    else keys_s = k[11:0];
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 200 && !mon_done; i++) @(negedge clk);
    chk(nm, 64'(mon_done), 64'd1);
  endtask

  // Collects events until the next scan-done pulse and checks them against v
  task automatic collect(input vec_t v, input string tag);
    int          cnt = 0;
    int          n = 0;
    int          herr = 0;
    logic [31:0] lg = '0;
    logic [3:0]  last = mon_evt;
    do begin
      @(negedge clk);
      cnt++;
      if (v.mid_en && cnt == 10) set_keys(v.dut, v.mid);
      if (mon_on || mon_off) begin
        if (n < 4) lg[8*n +: 8] = {mon_on, mon_off, mon_st, 1'b0, mon_evt};
        n++;
      end else if (mon_st || (mon_evt != last)) begin
        herr++;
      end
      last = mon_evt;
    end while (!mon_done && cnt < 200);
    chk({tag, ".period"}, 64'(cnt), 64'(v.period));
    chk({tag, ".n_ev"},   64'(n),    64'(v.n_ev));
    chk({tag, ".events"}, 64'(lg),   64'(v.ev));
    chk({tag, ".active"}, 64'(mon_act), 64'(v.act));
    chk({tag, ".vkeys"},  64'(mon_vk),  64'(v.vk));
    chk({tag, ".hold"},   64'(herr),    64'd0);
  endtask

  initial begin
    rst = 1'b1; sel = 0;
    keys_a = '0; keys_n = '0; keys_s = '0;

    // Default instance: 88 keys, 4 voices, stealing
    vt.push_back(mkv(0, kb(40),             0, '0,     1, 32'h00000080, 4'h1, pk4(40, 0, 0, 0)));
    vt.push_back(mkv(0, kb(),               0, '0,     1, 32'h00000040, 4'h0, pk4(40, 0, 0, 0)));
    vt.push_back(mkv(0, kb(10, 20, 30, 40), 0, '0,     4, 32'h83828180, 4'hF, pk4(10, 20, 30, 40)));
    vt.push_back(mkv(0, kb(10, 30, 40),     0, '0,     1, 32'h00000041, 4'hD, pk4(10, 20, 30, 40)));
    vt.push_back(mkv(0, kb(10, 20, 30, 40), 0, '0,     1, 32'h00000081, 4'hF, pk4(10, 20, 30, 40)));
    vt.push_back(mkv(0, kb(10, 20, 30, 40, 50), 0, '0, 1, 32'h000000A0, 4'hF, pk4(50, 20, 30, 40)));
    vt.push_back(mkv(0, kb(20, 30, 40, 50), 0, '0,     0, 32'h00000000, 4'hF, pk4(50, 20, 30, 40)));
    vt.push_back(mkv(0, kb(),               0, '0,     4, 32'h40434241, 4'h0, pk4(50, 20, 30, 40)));
    vt.push_back(mkv(0, kb(),               1, kb(5),  0, 32'h00000000, 4'h0, pk4(50, 20, 30, 40)));
    vt.push_back(mkv(0, kb(5),              0, '0,     1, 32'h00000080, 4'h1, pk4(5, 20, 30, 40)));
    vt.push_back(mkv(0, kb(),               1, kb(5),  1, 32'h00000040, 4'h0, pk4(5, 20, 30, 40)));
    vt.push_back(mkv(0, kb(5),              0, '0,     1, 32'h00000080, 4'h1, pk4(5, 20, 30, 40)));
    // Non-stealing instance
    vt.push_back(mkv(1, kb(10, 20, 30, 40), 0, '0,     4, 32'h83828180, 4'hF, pk4(10, 20, 30, 40)));
    vt.push_back(mkv(1, kb(10, 20, 30, 40, 50), 0, '0, 0, 32'h00000000, 4'hF, pk4(10, 20, 30, 40)));
    vt.push_back(mkv(1, kb(10, 20, 30, 40), 0, '0,     0, 32'h00000000, 4'hF, pk4(10, 20, 30, 40)));
    vt.push_back(mkv(1, kb(),               0, '0,     4, 32'h43424140, 4'h0, pk4(10, 20, 30, 40)));
    // Small instance: 12 keys, 2 voices, 4-bit key index
    vt.push_back(mkv(2, kb(3),              0, '0,     1, 32'h00000080, 4'h1, 28'h03));
    vt.push_back(mkv(2, kb(),               0, '0,     1, 32'h00000040, 4'h0, 28'h03));
    vt.push_back(mkv(2, kb(2, 7),           0, '0,     2, 32'h00008180, 4'h3, 28'h72));
    vt.push_back(mkv(2, kb(2),              0, '0,     1, 32'h00000041, 4'h1, 28'h72));
    vt.push_back(mkv(2, kb(2, 7),           0, '0,     1, 32'h00000081, 4'h3, 28'h72));
    vt.push_back(mkv(2, kb(2, 7, 9),        0, '0,     1, 32'h000000A0, 4'h3, 28'h79));
    vt.push_back(mkv(2, kb(7, 9),           0, '0,     0, 32'h00000000, 4'h3, 28'h79));
    vt.push_back(mkv(2, kb(),               0, '0,     2, 32'h00004041, 4'h0, 28'h79));

    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      sel = d;
      #1;
      chk($sformatf("reset_d%0d", d),
          64'({mon_act, mon_vk, mon_on, mon_off, mon_st, mon_evt, mon_done}), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    foreach (vt[i]) begin
      sel = vt[i].dut;
      #1;
      wait_done($sformatf("v%0d.sync", i));
      set_keys(vt[i].dut, vt[i].keys);
      collect(vt[i], $sformatf("v%0d", i));
    end

    // Reset in the middle of a scan with keys held, then re-emission after release
    sel = 0;
    #1;
    wait_done("rstmid.sync");
    keys_a = kb(5, 60);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rstmid.zero",
        64'({mon_act, mon_vk, mon_on, mon_off, mon_st, mon_evt, mon_done}), 64'd0);
    rst = 1'b0;
    collect(mkv(0, kb(5, 60), 0, '0, 2, 32'h00008180, 4'h3, pk4(5, 60, 0, 0)), "rstmid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
